// File: rtl/vec_token_writer.sv
// rtl/vec_token_writer.sv - parallel word to ASCII '0'/'1' token with space/newline terminator
// Optional line counter port `lines` is compiled in with VEC_TOKEN_WRITER_LINES_EN.
module vec_token_writer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
`ifdef VEC_TOKEN_WRITER_LINES_EN
  ,
  output logic [15:0]      lines
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TERM = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [WIDTH-1:0] word_q;
  logic            last_q;
  logic            load;

  // All outputs decode from registered state only; out_ready/in_valid only steer next state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = IDX_MAX;
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = {7'b0011000, word_q[idx_q]};
        if (out_ready) begin
          if (idx_q == '0) begin
            state_d = TERM;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      TERM: begin
        out_valid = 1'b1;
        out_data  = last_q ? 8'h0A : 8'h20;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        word_q <= in_word;
        last_q <= in_last;
      end
    end
  end

`ifdef VEC_TOKEN_WRITER_LINES_EN
  // Counts newline terminators actually handed downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      lines <= 16'h0000;
    end else if (state_q == TERM && out_ready && last_q) begin
      lines <= lines + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_token_writer.sv
// tb/tb_vec_token_writer.sv - table-driven bench for vec_token_writer (WIDTH=8 and WIDTH=1)
module tb_vec_token_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] in_word1;
  logic       in_last1;
  logic       out_valid1;
  logic       out_ready1;
  logic [7:0] out_data1;
  logic       busy1;
`ifdef VEC_TOKEN_WRITER_LINES_EN
  logic [15:0] lines;
  logic [15:0] lines1;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  word;
    logic        last;
    logic [71:0] exp;
    bit          noise;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  vec_token_writer #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef VEC_TOKEN_WRITER_LINES_EN
    , .lines(lines)
`endif
  );

  vec_token_writer #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_word(in_word1), .in_last(in_last1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
`ifdef VEC_TOKEN_WRITER_LINES_EN
    , .lines(lines1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send8(input logic [7:0] w, input logic l, input logic [71:0] exp, input bit noise);
    chk("pre_in_ready", 16'(in_ready), 16'd1);
    chk("pre_out_valid", 16'(out_valid), 16'd0);
    in_valid  = 1'b1;
    in_word   = w;
    in_last   = l;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_word  = ~w;
    in_last  = ~l;
    for (int i = 0; i < 9; i++) begin
      chk("tok_valid", 16'(out_valid), 16'd1);
      chk("tok_data", 16'(out_data), 16'(exp[8*(8-i) +: 8]));
      chk("tok_in_ready", 16'(in_ready), 16'd0);
      chk("tok_busy", 16'(busy), 16'd1);
      if (noise) begin
        in_valid = 1'($urandom);
        in_word  = 8'($urandom);
        in_last  = 1'($urandom);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bubble_valid", 16'(out_valid), 16'd0);
    chk("bubble_in_ready", 16'(in_ready), 16'd1);
    chk("bubble_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    logic [71:0] bp_exp;
    logic [71:0] rs_exp;

    tbl[0] = '{8'hA5, 1'b1, "10100101\n", 1'b0};
    tbl[1] = '{8'h03, 1'b0, "00000011 ", 1'b0};
    tbl[2] = '{8'hFF, 1'b1, "11111111\n", 1'b0};
    tbl[3] = '{8'h00, 1'b0, "00000000 ", 1'b0};
    tbl[4] = '{8'h5A, 1'b1, "01011010\n", 1'b0};
    tbl[5] = '{8'hC3, 1'b0, "11000011 ", 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_word = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_word1 = 1'b0; in_last1 = 1'b0; out_ready1 = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'h00);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst1_out_valid", 16'(out_valid1), 16'd0);
`ifdef VEC_TOKEN_WRITER_LINES_EN
    chk("rst_lines", lines, 16'd0);
`endif
    rst = 1'b0;
    tick();

    // Back-to-back tokens: each send starts from the mandatory bubble of the previous one.
    for (int v = 0; v < 6; v++) begin
      send8(tbl[v].word, tbl[v].last, tbl[v].exp, tbl[v].noise);
    end
`ifdef VEC_TOKEN_WRITER_LINES_EN
    chk("lines_after_table", lines, 16'd3);
`endif

    // Backpressure on the first character of 0x80.
    bp_exp = "10000000 ";
    in_valid = 1'b1; in_word = 8'h80; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 16'(out_valid), 16'd1);
      chk("bp_hold_data", 16'(out_data), 16'h31);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("bp_tok_data", 16'(out_data), 16'(bp_exp[8*(8-i) +: 8]));
      tick();
    end
    chk("bp_bubble_valid", 16'(out_valid), 16'd0);

    // Reset after three bytes of 0x0F: token abandoned, no terminator.
    in_valid = 1'b1; in_word = 8'h0F; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rs_pre_data", 16'(out_data), 16'h30);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rs_out_valid", 16'(out_valid), 16'd0);
    chk("rs_in_ready", 16'(in_ready), 16'd1);
    chk("rs_busy", 16'(busy), 16'd0);
    chk("rs_out_data", 16'(out_data), 16'h00);
`ifdef VEC_TOKEN_WRITER_LINES_EN
    chk("rs_lines", lines, 16'd0);
`endif
    rst = 1'b0;
    tick();
    chk("rs_idle_valid", 16'(out_valid), 16'd0);
    rs_exp = "00000001\n";
    send8(8'h01, 1'b1, rs_exp, 1'b0);
`ifdef VEC_TOKEN_WRITER_LINES_EN
    chk("lines_after_reset_word", lines, 16'd1);
`endif

    // WIDTH=1 instance: "1\n" then "0 ", two cycles each.
    in_valid1 = 1'b1; in_word1 = 1'b1; in_last1 = 1'b1;
    tick();
    in_valid1 = 1'b0; in_word1 = 1'b0;
    chk("w1_a_char", 16'(out_data1), 16'h31);
    chk("w1_a_in_ready", 16'(in_ready1), 16'd0);
    tick();
    chk("w1_a_term", 16'(out_data1), 16'h0A);
    chk("w1_a_term_valid", 16'(out_valid1), 16'd1);
    tick();
    chk("w1_a_bubble", 16'(out_valid1), 16'd0);
    in_valid1 = 1'b1; in_word1 = 1'b0; in_last1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    chk("w1_b_char", 16'(out_data1), 16'h30);
    tick();
    chk("w1_b_term", 16'(out_data1), 16'h20);
    tick();
    chk("w1_b_bubble", 16'(out_valid1), 16'd0);
    chk("w1_b_busy", 16'(busy1), 16'd0);
`ifdef VEC_TOKEN_WRITER_LINES_EN
    chk("w1_lines", lines1, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
